// File: rtl/demux_cond_l1.sv
// Two-lane pairing demux: each input lane gathers two consecutive valid words
// and presents them together, one cycle later, on its own pair of output lanes.

module demux_cond_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             pend,
  output logic             validout,
  output logic [WIDTH-1:0] data_lo,
  output logic [WIDTH-1:0] data_hi
);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pair_done;
  logic             validout_q;
  logic [WIDTH-1:0] lo_q, hi_q;

  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    pair_done = 1'b0;
    if (valid) begin
      case (phase_q)
        EVEN: begin
          hold_d  = data;
          phase_d = ODD;
        end
        ODD: begin
          pair_done = 1'b1;
          phase_d   = EVEN;
        end
        default: phase_d = EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= EVEN;
      hold_q     <= '0;
      validout_q <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      validout_q <= pair_done;
      // Output words only change on a completed pair; otherwise they hold.
      if (pair_done) begin
        lo_q <= hold_q;
        hi_q <= data;
      end
    end
  end

  // The phase bit is the lane's whole FSM state and doubles as its debug view.
  assign pend     = (phase_q == ODD);
  assign validout = validout_q;
  assign data_lo  = lo_q;
  assign data_hi  = hi_q;

endmodule

// Handshake: valid-only push. A word is taken on every rising edge with
// validk=1; there is no ready, so the block never stalls its source.
module demux_cond_l1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             valid0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  output logic             validout0,
  output logic             validout1,
  output logic             validout2,
  output logic             validout3,
  output logic [WIDTH-1:0] dataout0,
  output logic [WIDTH-1:0] dataout1,
  output logic [WIDTH-1:0] dataout2,
  output logic [WIDTH-1:0] dataout3,
  output logic             pend0,
  output logic             pend1
);

  logic lane0_valid, lane1_valid;

  demux_cond_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk      (clk_2f),
    .rst_n    (reset_L),
    .valid    (valid0),
    .data     (data_in0),
    .pend     (pend0),
    .validout (lane0_valid),
    .data_lo  (dataout0),
    .data_hi  (dataout1)
  );

  demux_cond_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk      (clk_2f),
    .rst_n    (reset_L),
    .valid    (valid1),
    .data     (data_in1),
    .pend     (pend1),
    .validout (lane1_valid),
    .data_lo  (dataout2),
    .data_hi  (dataout3)
  );

  assign validout0 = lane0_valid;
  assign validout1 = lane0_valid;
  assign validout2 = lane1_valid;
  assign validout3 = lane1_valid;

endmodule

// File: tb/tb_demux_cond_l1.sv
// Bench for demux_cond_l1: a lane model pushes expected pairs tagged with their
// due cycle; a negedge monitor pops and compares every output each cycle.

module tb_demux_cond_l1;

  localparam int W  = 8;
  localparam int QW = 16 + 2 * W;

  // clock / reset
  logic clk_2f = 1'b0;
  logic reset_L;
  always #5 clk_2f = ~clk_2f;

  logic         valid0, valid1;
  logic [W-1:0] data_in0, data_in1;
  logic         validout0, validout1, validout2, validout3;
  logic [W-1:0] dataout0, dataout1, dataout2, dataout3;
  logic         pend0, pend1;

  demux_cond_l1 #(.WIDTH(W)) dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .valid0    (valid0),
    .valid1    (valid1),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .validout0 (validout0),
    .validout1 (validout1),
    .validout2 (validout2),
    .validout3 (validout3),
    .dataout0  (dataout0),
    .dataout1  (dataout1),
    .dataout2  (dataout2),
    .dataout3  (dataout3),
    .pend0     (pend0),
    .pend1     (pend1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_2f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: entries are {due_cycle[15:0], held_word, odd_word}
  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];

  logic         m_phase[2];
  logic [W-1:0] m_hold[2];
  logic [W-1:0] m_lo[2];
  logic [W-1:0] m_hi[2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 1'b0;
      m_hold[k]  = '0;
      m_lo[k]    = '0;
      m_hi[k]    = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called just after the edge that accepted the word: output is due this cycle.
  task automatic model_accept(input int k, input logic v, input logic [W-1:0] d);
    if (v) begin
      if (!m_phase[k]) begin
        m_hold[k]  = d;
        m_phase[k] = 1'b1;
      end else begin
        if (k == 0) exp_q0.push_back({cyc[15:0], m_hold[k], d});
        else        exp_q1.push_back({cyc[15:0], m_hold[k], d});
        m_phase[k] = 1'b0;
      end
    end
  endtask

  // driver tasks: called at posedge+1, return at the following posedge+1
  task automatic drive(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1);
    valid0   = v0;
    data_in0 = d0;
    valid1   = v1;
    data_in1 = d1;
    @(posedge clk_2f);
    #1;
    model_accept(0, v0, d0);
    model_accept(1, v1, d1);
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, W'($urandom_range(0, 255)), 1'b0, W'($urandom_range(0, 255)));
  endtask

  task automatic reset_pulse(input int n);
    reset_L = 1'b0;
    model_clear();
    #1;
    check("async_rst_pend0", 32'(pend0), 32'd0);
    check("async_rst_dataout0", 32'(dataout0), 32'd0);
    check("async_rst_dataout1", 32'(dataout1), 32'd0);
    repeat (n) @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
  endtask

  // monitor: every output compared against the model on each falling edge
  always @(negedge clk_2f) begin
    logic          ev0, ev1;
    logic [QW-1:0] e;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (exp_q0.size() > 0 && exp_q0[0][QW-1:2*W] == cyc[15:0]) begin
      e = exp_q0.pop_front();
      ev0 = 1'b1;
      m_lo[0] = e[2*W-1:W];
      m_hi[0] = e[W-1:0];
    end
    if (exp_q1.size() > 0 && exp_q1[0][QW-1:2*W] == cyc[15:0]) begin
      e = exp_q1.pop_front();
      ev1 = 1'b1;
      m_lo[1] = e[2*W-1:W];
      m_hi[1] = e[W-1:0];
    end
    check("validout0", 32'(validout0), 32'(ev0));
    check("validout1", 32'(validout1), 32'(ev0));
    check("validout2", 32'(validout2), 32'(ev1));
    check("validout3", 32'(validout3), 32'(ev1));
    check("dataout0", 32'(dataout0), 32'(m_lo[0]));
    check("dataout1", 32'(dataout1), 32'(m_hi[0]));
    check("dataout2", 32'(dataout2), 32'(m_lo[1]));
    check("dataout3", 32'(dataout3), 32'(m_hi[1]));
    check("pend0", 32'(pend0), 32'(m_phase[0]));
    check("pend1", 32'(pend1), 32'(m_phase[1]));
  end

  initial begin
    reset_L  = 1'b0;
    valid0   = 1'b0;
    valid1   = 1'b0;
    data_in0 = '0;
    data_in1 = '0;
    model_clear();
    repeat (3) @(posedge clk_2f);
    #1;
    reset_L = 1'b1;

    // reset then idle
    idle(4);

    // lane 0 burst: pairs 11/22 and 33/44 back to back
    drive(1'b1, 8'h11, 1'b0, 8'h00);
    drive(1'b1, 8'h22, 1'b0, 8'h00);
    drive(1'b1, 8'h33, 1'b0, 8'h00);
    drive(1'b1, 8'h44, 1'b0, 8'h00);
    idle(2);
    check("burst_dataout0", 32'(dataout0), 32'h33);
    check("burst_dataout1", 32'(dataout1), 32'h44);

    // gap tolerance on lane 1
    drive(1'b0, 8'h00, 1'b1, 8'hA5);
    idle(5);
    check("gap_pend1", 32'(pend1), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 8'h5A);
    check("gap_validout2", 32'(validout2), 32'd1);
    check("gap_dataout2", 32'(dataout2), 32'hA5);
    check("gap_dataout3", 32'(dataout3), 32'h5A);
    idle(2);

    // simultaneous completions on both lanes
    drive(1'b1, 8'h01, 1'b1, 8'hF1);
    drive(1'b1, 8'h02, 1'b1, 8'hF2);
    check("sim_valid_all", 32'({validout0, validout1, validout2, validout3}), 32'hF);
    idle(2);

    // reset mid-pair discards the held half
    drive(1'b1, 8'h77, 1'b0, 8'h00);
    reset_pulse(2);
    drive(1'b1, 8'h88, 1'b0, 8'h00);
    drive(1'b1, 8'h99, 1'b0, 8'h00);
    check("rst_pair_lo", 32'(dataout0), 32'h88);
    check("rst_pair_hi", 32'(dataout1), 32'h99);
    idle(2);

    // output hold over a long idle stretch
    drive(1'b1, 8'h10, 1'b0, 8'h00);
    drive(1'b1, 8'h20, 1'b0, 8'h00);
    idle(10);
    check("hold_dataout0", 32'(dataout0), 32'h10);
    check("hold_dataout1", 32'(dataout1), 32'h20);
    check("hold_validout0", 32'(validout0), 32'd0);

    // random traffic on both lanes
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
    idle(3);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_cond_l1.md
DEMUX_COND_L1 -- requirements
Module: demux_cond_l1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width.
REQ-002 The block SHALL have port clk_2f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port valid0, input, 1 bit: lane 0 input word valid.
REQ-005 The block SHALL have port valid1, input, 1 bit: lane 1 input word valid.
REQ-006 The block SHALL have port data_in0, input, WIDTH bits: lane 0 input word.
REQ-007 The block SHALL have port data_in1, input, WIDTH bits: lane 1 input word.
REQ-008 The block SHALL have ports validout0..validout3, output, 1 bit each: output lane valid.
REQ-009 The block SHALL have ports dataout0..dataout3, output, WIDTH bits each: output lane words.
REQ-010 The block SHALL have ports pend0 and pend1, output, 1 bit each: a half-pair is held on input lane 0 or 1.

Function
REQ-011 Input lane 0 SHALL feed output lanes 0 and 1; input lane 1 SHALL feed output lanes 2 and 3; the two input lanes SHALL be fully independent.
REQ-012 Each input lane SHALL have a phase bit: EVEN (0) or ODD (1).
REQ-013 A word is accepted on lane k in a cycle with validk=1; data_ink is ignored when validk=0.
REQ-014 If an accepted word arrives in EVEN, it SHALL be stored in hold register k, and the phase SHALL move to ODD.
REQ-015 If an accepted word arrives in ODD, the lane SHALL complete a pair, and the phase SHALL return to EVEN.
REQ-016 On pair completion on lane 0, in the next cycle: dataout0 SHALL equal the held word, dataout1 SHALL equal the ODD word, and validout0 = validout1 = 1.
REQ-017 Lane 1 SHALL behave identically, driving dataout2 (held word), dataout3 (ODD word), validout2 and validout3.
REQ-018 Latency from the ODD word to the outputs SHALL be exactly 1 cycle; all outputs SHALL be registered.
REQ-019 The validout bits of a lane pair SHALL be high for exactly one cycle per completed pair and low otherwise.
REQ-020 The dataout values of a lane pair SHALL hold their last value until the next pair completes on that lane.
REQ-021 Gaps (valid low) SHALL NOT alter phase or hold contents; a half-pair waits indefinitely.
REQ-022 Back-to-back valid words SHALL be sustained at full rate: one pair output every 2 cycles per lane, with no stall.
REQ-023 pendk SHALL equal the phase bit of lane k (1 while a half-pair is held).
REQ-024 Simultaneous completions on both lanes in the same cycle SHALL produce all four validout bits high in the same cycle.

Reset
REQ-025 While reset_L=0, regardless of clock: both phases EVEN, hold registers 0, all dataout 0, all validout 0, pend0 = pend1 = 0.
REQ-026 Reset asserted mid-pair SHALL discard the held half-pair; the first accepted word after release SHALL be treated as EVEN.
REQ-027 On reset release, the block SHALL accept input on the first rising edge where reset_L=1.

Verification
REQ-028 Reset then idle: reset_L=0 for 3 cycles, then 1 with valid0 = valid1 = 0 -> all outputs 0 and pend 0 throughout.
REQ-029 Lane 0 burst: valid0=1 for 4 cycles with data 0x11, 0x22, 0x33, 0x44 -> cycle 2 out: dataout0=0x11, dataout1=0x22, validout0/1=1; cycle 4 out: 0x33/0x44; validout low in cycles 1 and 3.
REQ-030 Gap tolerance: lane 1 sends 0xA5, then valid1=0 for 5 cycles, then 0x5A -> pend1=1 during the gap; one cycle after 0x5A: dataout2=0xA5, dataout3=0x5A, validout2/3=1.
REQ-031 Simultaneous lanes: both lanes send pairs (0x01, 0x02) and (0xF1, 0xF2) on the same cycles -> all four validout pulse together; data 0x01/0x02/0xF1/0xF2.
REQ-032 Reset mid-pair: lane 0 sends 0x77, reset pulses, then lane 0 sends 0x88, 0x99 -> output pair 0x88/0x99; 0x77 never appears.
REQ-033 Hold check: after a pair 0x10/0x20, 10 idle cycles -> dataout0=0x10 and dataout1=0x20 are held, and validout0/1=0.
